// File: rtl/centroid_update_pkg.sv
// Shared constants, state encoding and helpers for the k-means centroid update block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kmeans_pkg;

  localparam int CENTROID_NUM = 8;
  localparam int DIM_NUM      = 7;
  localparam int CORD_W       = 13;
  localparam int ACC_CORD_W   = 22;
  localparam int CNT_W        = 10;

  localparam int DATA_W    = DIM_NUM * CORD_W;
  localparam int ACC_W     = DIM_NUM * ACC_CORD_W;
  localparam int SEL_W     = $clog2(CENTROID_NUM);
  localparam int DIM_IDX_W = $clog2(DIM_NUM);
  localparam int DIM_SLOTS = 2 ** DIM_IDX_W;
  localparam int DIV_CNT_W = $clog2(ACC_CORD_W + 1);

  typedef enum logic [2:0] {
    CU_IDLE,
    CU_LOAD,
    CU_DIV,
    CU_STORE,
    CU_WRITE,
    CU_NEXT,
    CU_DONE
  } cu_state_t;

  // Clamp a full-width quotient into one coordinate field.
  function automatic logic [CORD_W-1:0] sat_cord(input logic [ACC_CORD_W-1:0] q);
    if (|q[ACC_CORD_W-1:CORD_W]) return {CORD_W{1'b1}};
    else                         return q[CORD_W-1:0];
  endfunction

endpackage

// File: rtl/centroid_update_if.sv
// Centroid-load bus between the update engine (master) and the classifier (slave).
// Latency: lookups (accum/count/cur) are combinational functions of centroid_sel.
// Backpressure: none; the classifier must accept every one-cycle centroid_en strobe.
interface centroid_update_if
  import kmeans_pkg::*;
  ();

  logic [SEL_W-1:0]        centroid_sel;
  logic [ACC_W-1:0]        accum_data;
  logic [CNT_W-1:0]        count_data;
  logic [DATA_W-1:0]       cur_centroid;
  logic [DATA_W-1:0]       centroid_data;
  logic [CENTROID_NUM-1:0] centroid_en;

  modport master (
    output centroid_sel,
    output centroid_data,
    output centroid_en,
    input  accum_data,
    input  count_data,
    input  cur_centroid
  );

  modport slave (
    input  centroid_sel,
    input  centroid_data,
    input  centroid_en,
    output accum_data,
    output count_data,
    output cur_centroid
  );

endinterface

// File: rtl/centroid_update_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: ACC_CORD_W cycles after the load cycle; last flags the final iteration.
// Backpressure: none; a load while busy restarts the division.
// Ports: load/dividend/divisor in, busy/last/quotient out; quotient valid once busy drops.
module seq_divider
  import kmeans_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ACC_CORD_W-1:0] dividend,
  input  logic [CNT_W-1:0]      divisor,
  output logic                  busy,
  output logic                  last,
  output logic [ACC_CORD_W-1:0] quotient
);

  logic [CNT_W-1:0]      rem_q;
  logic [CNT_W-1:0]      dvsr_q;
  logic [ACC_CORD_W-1:0] quo_q;
  logic [DIV_CNT_W-1:0]  cnt_q;
  logic [CNT_W:0]        trial;
  logic [CNT_W-1:0]      diff;

  // The dividend register doubles as the quotient: each cycle shifts its MSB
  // into the partial remainder and the new quotient bit into its LSB.
  assign trial = {rem_q, quo_q[ACC_CORD_W-1]};
  // When trial >= divisor the difference is below the divisor, so it fits CNT_W bits.
  assign diff  = trial[CNT_W-1:0] - dvsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvsr_q <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= '0;
      dvsr_q <= divisor;
      quo_q  <= dividend;
      cnt_q  <= DIV_CNT_W'(ACC_CORD_W);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_CNT_W'(1);
      if (trial >= {1'b0, dvsr_q}) begin
        rem_q <= diff;
        quo_q <= {quo_q[ACC_CORD_W-2:0], 1'b1};
      end else begin
        rem_q <= trial[CNT_W-1:0];
        quo_q <= {quo_q[ACC_CORD_W-2:0], 1'b0};
      end
    end
  end

  assign busy     = (cnt_q != '0);
  assign last     = (cnt_q == DIV_CNT_W'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/centroid_update.sv
// Centroid update engine: new centroid = per-coordinate floor(sum / count), saturated.
// Latency: 164 cycles per populated centroid, 2 per empty one, plus 1 DONE cycle.
// Backpressure: none; start is only sampled in IDLE, strobes are fire-and-forget.
// Ports: clk/rst/start in; cu (master) carries centroid_sel, lookups and the
// centroid_data/centroid_en write strobe; busy, done (pulse) and sticky moved out.
module centroid_update
  import kmeans_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  centroid_update_if.master         cu,
  output logic                      busy,
  output logic                      done,
  output logic                      moved
);

  cu_state_t state_q, state_n;

  logic [SEL_W-1:0]        k_q;
  logic [SEL_W-1:0]        sel_q;
  logic [DIM_IDX_W-1:0]    c_q;
  logic [DIM_IDX_W-1:0]    c_nxt;
  logic [ACC_W-1:0]        acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       cur_q;
  logic [CORD_W-1:0]       res_arr [DIM_NUM];
  logic [DATA_W-1:0]       res_next_pk;
  logic [DATA_W-1:0]       out_data_q;
  logic [CENTROID_NUM-1:0] en_q;
  logic                    moved_q;

  logic [ACC_CORD_W-1:0]   acc_arr [DIM_SLOTS];
  logic                    div_load;
  logic [ACC_CORD_W-1:0]   div_dvd;
  logic [CNT_W-1:0]        div_dvs;
  logic                    div_busy;
  logic                    div_last;
  logic [ACC_CORD_W-1:0]   div_quo;
  logic [CORD_W-1:0]       sat_val;
  logic                    count_zero;
  logic                    last_coord;
  logic                    last_cent;

  // Unused slots beyond DIM_NUM read as zero so c_nxt never indexes past the array.
  always_comb begin
    for (int i = 0; i < DIM_SLOTS; i++) acc_arr[i] = '0;
    for (int i = 0; i < DIM_NUM; i++)   acc_arr[i] = acc_q[i*ACC_CORD_W +: ACC_CORD_W];
  end

  assign c_nxt      = c_q + DIM_IDX_W'(1);
  assign count_zero = (cu.count_data == '0);
  assign last_coord = (c_q == DIM_IDX_W'(DIM_NUM - 1));
  assign last_cent  = (k_q == SEL_W'(CENTROID_NUM - 1));
  assign sat_val    = sat_cord(div_quo);

  // Coordinate 0 is fed straight from the lookup in LOAD (its latch lands at the
  // same edge); later coordinates come from the latched accumulator.
  assign div_load = ((state_q == CU_LOAD) && !count_zero) ||
                    ((state_q == CU_STORE) && !last_coord);
  assign div_dvd  = (state_q == CU_LOAD) ? cu.accum_data[ACC_CORD_W-1:0] : acc_arr[c_nxt];
  assign div_dvs  = (state_q == CU_LOAD) ? cu.count_data : cnt_q;

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .busy     (div_busy),
    .last     (div_last),
    .quotient (div_quo)
  );

  // Result register with the coordinate being stored this cycle merged in,
  // so the final STORE can hand the complete centroid to the output register.
  always_comb begin
    res_next_pk = '0;
    for (int i = 0; i < DIM_NUM; i++) begin
      res_next_pk[i*CORD_W +: CORD_W] = (DIM_IDX_W'(i) == c_q) ? sat_val : res_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= CU_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      CU_IDLE:  if (start) state_n = CU_LOAD;
      CU_LOAD:  state_n = count_zero ? CU_NEXT : CU_DIV;
      CU_DIV:   if (div_busy && div_last) state_n = CU_STORE;
      CU_STORE: state_n = last_coord ? CU_WRITE : CU_DIV;
      CU_WRITE: state_n = CU_NEXT;
      CU_NEXT:  state_n = last_cent ? CU_DONE : CU_LOAD;
      CU_DONE:  state_n = CU_IDLE;
      default:  state_n = CU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      sel_q      <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      cur_q      <= '0;
      out_data_q <= '0;
      en_q       <= '0;
      moved_q    <= 1'b0;
      for (int i = 0; i < DIM_NUM; i++) res_arr[i] <= '0;
    end else begin
      case (state_q)
        CU_IDLE: begin
          if (start) begin
            k_q     <= '0;
            sel_q   <= '0;
            moved_q <= 1'b0;
          end
        end
        CU_LOAD: begin
          acc_q <= cu.accum_data;
          cnt_q <= cu.count_data;
          cur_q <= cu.cur_centroid;
          c_q   <= '0;
        end
        CU_STORE: begin
          res_arr[c_q] <= sat_val;
          if (!last_coord) begin
            c_q <= c_nxt;
          end else begin
            out_data_q <= res_next_pk;
            en_q       <= CENTROID_NUM'(1) << k_q;
          end
        end
        CU_WRITE: begin
          en_q    <= '0;
          moved_q <= moved_q | (out_data_q != cur_q);
        end
        CU_NEXT: begin
          if (!last_cent) begin
            k_q   <= k_q + SEL_W'(1);
            sel_q <= k_q + SEL_W'(1);
          end
        end
        CU_DONE: k_q <= '0;
        default: ;
      endcase
    end
  end

  assign cu.centroid_sel  = sel_q;
  assign cu.centroid_data = out_data_q;
  assign cu.centroid_en   = en_q;
  assign busy             = (state_q != CU_IDLE);
  assign done             = (state_q == CU_DONE);
  assign moved            = moved_q;

endmodule

// File: tb/tb_centroid_update.sv
module tb_centroid_update;
  import kmeans_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, moved;

  centroid_update_if cu_if ();

  logic [ACC_W-1:0]  acc_mem [CENTROID_NUM];
  logic [CNT_W-1:0]  cnt_mem [CENTROID_NUM];
  logic [DATA_W-1:0] cur_mem [CENTROID_NUM];

  assign cu_if.accum_data   = acc_mem[cu_if.centroid_sel];
  assign cu_if.count_data   = cnt_mem[cu_if.centroid_sel];
  assign cu_if.cur_centroid = cur_mem[cu_if.centroid_sel];

  centroid_update dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cu    (cu_if.master),
    .busy  (busy),
    .done  (done),
    .moved (moved)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int sum [DIM_NUM];
    int exp [DIM_NUM];
  } vec_t;

  typedef struct {
    int                k;
    logic [DATA_W-1:0] data;
    int                cyc;
  } sb_t;

  vec_t tbl [4];
  sb_t  sbq [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_cent(input int k);
    logic [DATA_W-1:0]     r;
    logic [ACC_CORD_W-1:0] a;
    int q;
    r = '0;
    for (int i = 0; i < DIM_NUM; i++) begin
      a = acc_mem[k][i*ACC_CORD_W +: ACC_CORD_W];
      q = int'(a) / int'(cnt_mem[k]);
      r[i*CORD_W +: CORD_W] = (q > 8191) ? 13'd8191 : CORD_W'(q);
    end
    return r;
  endfunction

  task automatic clear_mems();
    for (int k = 0; k < CENTROID_NUM; k++) begin
      acc_mem[k] = '0;
      cnt_mem[k] = '0;
      cur_mem[k] = '0;
    end
  endtask

  task automatic fill_uniform(input int cnt, input int sum);
    for (int k = 0; k < CENTROID_NUM; k++) begin
      cnt_mem[k] = CNT_W'(cnt);
      cur_mem[k] = '0;
      for (int i = 0; i < DIM_NUM; i++) acc_mem[k][i*ACC_CORD_W +: ACC_CORD_W] = ACC_CORD_W'(sum);
    end
  endtask

  // Pushes the expected strobe schedule, starts a pass and checks every strobe
  // plus the done cycle and final moved flag. If tbl_k >= 0, that centroid's
  // expected data comes from tbl_dat instead of the arithmetic model.
  task automatic run_pass(input string nm, input bit hold, input int tbl_k,
                          input logic [DATA_W-1:0] tbl_dat);
    int t, exp_done;
    bit mv, fin;
    sb_t e;
    sbq.delete();
    t = 1;
    mv = 1'b0;
    for (int k = 0; k < CENTROID_NUM; k++) begin
      if (cnt_mem[k] == '0) begin
        t += 2;
      end else begin
        e.k    = k;
        e.data = (k == tbl_k) ? tbl_dat : model_cent(k);
        e.cyc  = t + 162;
        sbq.push_back(e);
        if (e.data != cur_mem[k]) mv = 1'b1;
        t += 164;
      end
    end
    exp_done = t;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (cu_if.centroid_en != '0) begin
        if (sbq.size() == 0) begin
          chk({nm, " extra strobe"}, cu_if.centroid_en, 0);
        end else begin
          e = sbq.pop_front();
          chk({nm, " en"}, cu_if.centroid_en, CENTROID_NUM'(1) << e.k);
          chk({nm, " data"}, cu_if.centroid_data, e.data);
          chk({nm, " en cycle"}, n, e.cyc);
        end
      end
      if (done) begin
        chk({nm, " done cycle"}, n, exp_done);
        chk({nm, " moved"}, moved, mv);
        chk({nm, " missing strobes"}, sbq.size(), 0);
        fin = 1'b1;
        break;
      end
    end
    if (!fin) chk({nm, " timeout waiting for done"}, 0, 1);
  endtask

  initial begin
    logic [DATA_W-1:0] td;
    int seen;

    tbl[0].cnt = 3;    tbl[0].sum = '{10, 11, 0, 3, 4, 2, 1};
    tbl[0].exp = '{3, 3, 0, 1, 1, 0, 0};
    tbl[1].cnt = 1;    tbl[1].sum = '{4194303, 8191, 8192, 0, 1, 5, 100};
    tbl[1].exp = '{8191, 8191, 8191, 0, 1, 5, 100};
    tbl[2].cnt = 1023; tbl[2].sum = '{4194303, 1022, 1023, 2046, 0, 10230, 2097151};
    tbl[2].exp = '{4100, 0, 1, 2, 0, 10, 2050};
    tbl[3].cnt = 2;    tbl[3].sum = '{16383, 16384, 16381, 7, 8, 9, 1};
    tbl[3].exp = '{8191, 8191, 8190, 3, 4, 4, 0};

    clear_mems();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset moved", moved, 0);
    chk("reset en", cu_if.centroid_en, 0);
    chk("reset data", cu_if.centroid_data, 0);
    chk("reset sel", cu_if.centroid_sel, 0);
    rst = 1'b0;

    // Table vectors: one populated centroid per pass, all others empty.
    for (int v = 0; v < 4; v++) begin
      clear_mems();
      cnt_mem[v*2] = CNT_W'(tbl[v].cnt);
      td = '0;
      for (int i = 0; i < DIM_NUM; i++) begin
        acc_mem[v*2][i*ACC_CORD_W +: ACC_CORD_W] = ACC_CORD_W'(tbl[v].sum[i]);
        td[i*CORD_W +: CORD_W] = CORD_W'(tbl[v].exp[i]);
      end
      run_pass($sformatf("vec%0d", v), 1'b0, v*2, td);
    end

    // All populated: count 5, sums 50 -> every field 10, done in cycle 1313.
    fill_uniform(5, 50);
    td = '0;
    for (int i = 0; i < DIM_NUM; i++) td[i*CORD_W +: CORD_W] = 13'd10;
    chk("uniform model", model_cent(3), td);
    run_pass("uniform", 1'b0, -1, '0);

    // Zero-count skip: only centroid 1 populated, done in cycle 179.
    clear_mems();
    cnt_mem[1] = 10'd4;
    for (int i = 0; i < DIM_NUM; i++)
      acc_mem[1][i*ACC_CORD_W +: ACC_CORD_W] = ACC_CORD_W'($urandom_range(0, 40000));
    run_pass("skip", 1'b0, -1, '0);

    // Convergence: cur_centroid already equals the result -> moved stays 0.
    for (int k = 0; k < CENTROID_NUM; k++) begin
      cnt_mem[k] = CNT_W'($urandom_range(1, 1023));
      for (int i = 0; i < DIM_NUM; i++)
        acc_mem[k][i*ACC_CORD_W +: ACC_CORD_W] = ACC_CORD_W'($urandom_range(0, 4194303));
      cur_mem[k] = model_cent(k);
    end
    run_pass("converged", 1'b0, -1, '0);
    chk("converged moved", moved, 0);
    cur_mem[7][CORD_W] = ~cur_mem[7][CORD_W];
    run_pass("one off", 1'b0, -1, '0);
    chk("one off moved", moved, 1);

    // Reset in the middle of centroid 3's divide.
    fill_uniform(5, 50);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (498) @(negedge clk);
    chk("midrst sel before", cu_if.centroid_sel, 3);
    chk("midrst busy before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst sel", cu_if.centroid_sel, 0);
    chk("midrst en", cu_if.centroid_en, 0);
    chk("midrst data", cu_if.centroid_data, 0);
    chk("midrst done", done, 0);
    chk("midrst moved", moved, 0);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cu_if.centroid_en != '0) seen++;
    end
    chk("midrst no strobe", seen, 0);

    // start held high for a whole pass, then a back-to-back second pass.
    run_pass("held", 1'b1, -1, '0);
    @(negedge clk);
    chk("held idle gap busy", busy, 0);
    chk("held idle gap moved", moved, 1);
    @(negedge clk);
    chk("held restart busy", busy, 1);
    chk("held restart moved", moved, 0);
    chk("held restart sel", cu_if.centroid_sel, 0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centroid_update.md
Name: centroid_update

Overview:
- Producer side of the classify stage's centroid-load interface.
- After an accumulation pass, computes each new centroid: per coordinate, accumulated sum divided by member count.
- Writes each new centroid onto a shared centroid data bus with a one-hot enable pulse. The classifier latches it into its centroid register.
- Raises a sticky "moved" flag for the controller's convergence decision.

Parameters:
- centroid_num, 8, number of centroids.
- dim_num, 7, coordinates per point.
- cordinate_width, 13, unsigned coordinate width.
- accum_cord_width, 22, per-coordinate accumulator width.
- count_width, 10, member-count width.
- dataWidth, dim_num*cordinate_width (91), packed point width.
- accum_width, dim_num*accum_cord_width (154), packed accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin an update pass; sampled only in IDLE.
- centroid_sel  out  $clog2(centroid_num)  index of the centroid whose accumulator/count/current value is requested.
- accum_data  in  accum_width  sums for centroid_sel; coordinate i at [i*22 +: 22].
- count_data  in  count_width  member count for centroid_sel.
- cur_centroid  in  dataWidth  current centroid value for centroid_sel.
- centroid_data  out  dataWidth  new centroid; coordinate i at [i*13 +: 13].
- centroid_en  out  centroid_num  one-hot write strobe, 1 cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse at pass end.
- moved  out  1  sticky: some written centroid differs from its cur_centroid.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - rst=1 at an edge forces IDLE, k=0, c=0. All outputs go to 0: centroid_sel, centroid_data, centroid_en, busy, done, moved.
  - Reset mid-pass aborts with no further centroid_en pulse.
- Lookup timing: accum_data, count_data and cur_centroid are combinational lookups of centroid_sel. centroid_sel is a register equal to k and changes only on entry to LOAD.
- FSM states: IDLE, LOAD, DIV, STORE, WRITE, NEXT, DONE.
- IDLE:
  - start=1 → LOAD with k=0; moved cleared to 0.
  - start while not IDLE is ignored.
- LOAD (1 cycle):
  - Latch accum_data, count_data, cur_centroid; set c=0.
  - count==0 → NEXT. Centroid k keeps its old value and gets no strobe.
  - Otherwise → DIV.
- DIV (exactly accum_cord_width = 22 cycles):
  - Restoring unsigned divide of accumulator coordinate c by the latched count, one quotient bit per cycle.
- STORE (1 cycle):
  - Result = floor(quotient), saturated to 2^13-1 if quotient ≥ 2^13.
  - Written into field c of the result register.
  - c<dim_num-1 → c++, DIV; else → WRITE.
- WRITE (1 cycle):
  - centroid_data = result register, held stable until the next WRITE.
  - centroid_en = 1<<k for this cycle only.
  - moved |= (result != latched cur_centroid).
  - → NEXT.
- NEXT (1 cycle): k==centroid_num-1 → DONE; else k++, → LOAD.
- DONE (1 cycle): done=1, busy=1. → IDLE; k resets to 0.
- Latency:
  - Nonzero centroid: 1+7*23+1+1 = 164 cycles.
  - Zero-count centroid: 2 cycles.
  - Full pass, all nonzero: 8*164 = 1312 cycles, done in cycle 1313 after the start edge.
  - Full pass, all zero: done in cycle 17.
- Strobe ordering: at most one centroid_en bit high per cycle, in ascending k order.
- Unsigned arithmetic only. Truncating division, no rounding.

Decomposition:
- Shared package kmeans_pkg:
  - Constants: DIM_NUM, CORD_W, ACC_CORD_W, CNT_W, CENTROID_NUM.
  - Derived widths: DATA_W, ACC_W.
  - FSM state enum: cu_state_t.
- One natural sub-module: seq_divider.
  - ACC_CORD_W-bit dividend, CNT_W-bit divisor.
  - load/busy/quotient interface with a fixed 22-cycle latency.
  - Instantiated once and reused per coordinate.

Test Plan:
- Reset mid-pass: assert rst during DIV of centroid 3 → next cycle all outputs 0, busy=0. No centroid_en pulse follows. A fresh start then completes normally.
- All counts=5, all sums=0x32 (50) per coordinate:
  - centroid_en pulses 0x01,0x02,…,0x80, 164 cycles apart.
  - Every field of centroid_data = 10.
  - done in cycle 1313.
  - With cur_centroid=0, moved=1.
- Truncation and saturation:
  - count=3, sums 10,11,0,3,4,2,1 → fields 3,3,0,1,1,0,0.
  - count=1, sum=0x3FFFFF → field saturates to 8191.
- Zero-count skip: counts {0,4,0,0,0,0,0,0}.
  - Only centroid_en=0x02 asserted.
  - done in cycle 2+164+6*2+1 = 179.
- Convergence: cur_centroid equals the computed result for every centroid → moved=0 at done. Change one coordinate of centroid 7 by 1 → moved=1.
- start held high throughout a pass → ignored while busy. A second pass begins in the cycle after DONE returns to IDLE, and moved is cleared at that point.
